led_blink_sched: RTL
====================

Name: led_blink_sched

Overview:
- APB3 slave that sequences the board LED through programmable on/off blink trains, replacing direct software toggling of the LED.
- Sits on CoreAPB3 slot 0, clocked by the MSS fabric clock, with reset from the MSS M2F reset.
- Firmware writes timing, count and mode registers, then issues START; the block runs the train autonomously and reports completion through a status bit and an interrupt line.

Parameters:
- CNT_W, 24, width of the ON_TIME/OFF_TIME phase timers, in PCLK cycles.
- REP_W, 16, width of the blink repeat counter.

Ports:
- PCLK  in  1  fabric clock; all logic is on the rising edge.
- PRESERN  in  1  reset: synchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; only [4:2] are decoded, [1:0] are ignored.
- PWDATA  in  32  write data.
- PREADY  out  1  tied to 1 (zero wait states).
- PSLVERR  out  1  error response on an unmapped address.
- PRDATA  out  32  read data.
- LED  out  1  LED drive.
- DONE_IRQ  out  1  level interrupt, equal to STATUS.DONE & CTRL.IRQ_EN.

Behaviour:
- APB handshake
  - A write commits on the rising edge where PSEL & PENABLE & PWRITE = 1.
  - PRDATA is combinational when PSEL & !PWRITE, and 0 otherwise.
  - PSLVERR = PSEL & PENABLE & (PADDR[4:2] > 4); such writes have no effect and such reads return 0.
- Register map
  - 0x00 CTRL, R/W:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 STOP: write-1 pulse, reads 0.
    - bit2 LOOP.
    - bit3 INVERT.
    - bit4 IRQ_EN.
  - 0x04 ON_TIME[CNT_W-1:0], R/W.
  - 0x08 OFF_TIME[CNT_W-1:0], R/W.
  - 0x0C COUNT[REP_W-1:0], R/W.
  - 0x10 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear); [31:16] REMAIN (RO).
- Reset (PRESERN = 0 at an edge)
  - All registers = 0, state = IDLE.
  - LED = 0, DONE_IRQ = 0, PSLVERR = 0, PRDATA = 0.
- State machine: IDLE, ON, OFF. Raw LED = 1 in ON and 0 otherwise; the pin LED = raw LED ^ INVERT.
- START
  - Honoured only in IDLE; ignored while BUSY.
  - If COUNT = 0 and LOOP = 0: stay in IDLE and set DONE on the same edge.
  - Otherwise, on the committing edge: go to ON, load timer = max(ON_TIME,1) - 1, REMAIN = COUNT, clear DONE. LED is asserted from the cycle after that edge.
- ON
  - Timer decrements each cycle.
  - At timer = 0: go to OFF and load timer = max(OFF_TIME,1) - 1.
  - Net effect: LED is high for exactly max(ON_TIME,1) cycles.
- OFF
  - Timer decrements each cycle. At timer = 0:
    - If LOOP = 1: go to ON, reload the timer, REMAIN unchanged.
    - Else REMAIN decrements. If the new REMAIN is 0: go to IDLE and set DONE. Otherwise go to ON with the timer reloaded.
- BUSY = (state != IDLE).
- Timing registers may be written while BUSY; the new value takes effect at the next phase load. LOOP is sampled live.
- STOP
  - From any state: go to IDLE, raw LED = 0, DONE unchanged, REMAIN frozen.
  - START and STOP in the same write: STOP wins and nothing starts.
- DONE clear
  - A W1C write in the same cycle as a DONE set leaves DONE = 1 (set wins).
- Timers have no wrap-around: they only count down from a loaded value.
- Reset asserted mid-train forces IDLE and LED = 0 on that edge.

Test Plan:
- Reset check: hold PRESERN low for 3 cycles -> LED = 0, DONE_IRQ = 0, all registers read 0, PREADY = 1.
- Basic train: ON = 4, OFF = 2, COUNT = 3, START -> LED pattern 1111 00 1111 00 1111 00 starting the cycle after the write edge; BUSY falls and DONE = 1 on the 18th edge after START.
- Interrupt: IRQ_EN = 1 with the above train -> DONE_IRQ rises with DONE; a W1C write to STATUS bit1 drops DONE_IRQ the next cycle.
- Zero timing: ON = 0, OFF = 0, COUNT = 2 -> pattern 1 0 1 0. COUNT = 0, LOOP = 0, START -> no LED pulse, DONE = 1.
- STOP: LOOP = 1, ON = 3, OFF = 3, START, then STOP at cycle 7 -> LED = 0, BUSY = 0 the next cycle, DONE stays 0. START+STOP in one write -> stays IDLE.
- Errors: read/write at 0x14 and 0x1C -> PSLVERR = 1 in the access phase, PRDATA = 0, no register changes. START written while BUSY -> ignored, REMAIN continues unchanged.

Source files
------------

// File: rtl/led_blink_sched_if.sv
//------------------------------------------------------------------------------
// Module   : led_blink_sched_if
// Purpose  : APB3 signal bundle between CoreAPB3 and the LED blink scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface led_blink_sched_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

`default_nettype wire

// File: rtl/led_blink_sched.sv
//------------------------------------------------------------------------------
// Module   : led_blink_sched
// Purpose  : APB3 slave running programmable LED on/off blink trains with a
//            sticky DONE status and level interrupt.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_blink_sched #(
  parameter int CNT_W = 24,
  parameter int REP_W = 16
) (
  input  wire logic          PCLK,
  input  wire logic          PRESERN,
  led_blink_sched_if.slave   apb,
  output logic               LED,
  output logic               DONE_IRQ
);

  localparam logic [2:0]       c_addr_ctrl   = 3'd0;
  localparam logic [2:0]       c_addr_on     = 3'd1;
  localparam logic [2:0]       c_addr_off    = 3'd2;
  localparam logic [2:0]       c_addr_count  = 3'd3;
  localparam logic [2:0]       c_addr_status = 3'd4;
  localparam logic [CNT_W-1:0] c_tmr_one     = CNT_W'(1);
  localparam logic [REP_W-1:0] c_rep_one     = REP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_led_raw;
  logic             r_loop;
  logic             r_invert;
  logic             r_irq_en;
  logic             r_done;
  logic [CNT_W-1:0] r_on_time;
  logic [CNT_W-1:0] r_off_time;
  logic [REP_W-1:0] r_count;
  logic [REP_W-1:0] r_remain;
  logic [CNT_W-1:0] r_timer;

  logic [2:0]       w_addr;
  logic             w_addr_ok;
  logic             w_wr;
  logic             w_start;
  logic             w_stop;
  logic [CNT_W-1:0] w_on_load;
  logic [CNT_W-1:0] w_off_load;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_addr    = apb.PADDR[4:2];
  assign w_addr_ok = (w_addr <= c_addr_status);
  assign w_wr      = apb.PSEL && apb.PENABLE && apb.PWRITE && w_addr_ok;
  assign w_start   = w_wr && (w_addr == c_addr_ctrl) && apb.PWDATA[0];
  assign w_stop    = w_wr && (w_addr == c_addr_ctrl) && apb.PWDATA[1];

  // Phase lengths of zero behave as one cycle.
  assign w_on_load  = (r_on_time  == '0) ? '0 : r_on_time  - c_tmr_one;
  assign w_off_load = (r_off_time == '0) ? '0 : r_off_time - c_tmr_one;

  assign w_unused = ^{apb.PADDR, apb.PWDATA};

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      r_state    <= ST_IDLE;
      r_led_raw  <= 1'b0;
      r_loop     <= 1'b0;
      r_invert   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_on_time  <= '0;
      r_off_time <= '0;
      r_count    <= '0;
      r_remain   <= '0;
      r_timer    <= '0;
    end else begin
      if (w_wr) begin
        case (w_addr)
          c_addr_ctrl: begin
            r_loop   <= apb.PWDATA[2];
            r_invert <= apb.PWDATA[3];
            r_irq_en <= apb.PWDATA[4];
          end
          c_addr_on:     r_on_time  <= apb.PWDATA[CNT_W-1:0];
          c_addr_off:    r_off_time <= apb.PWDATA[CNT_W-1:0];
          c_addr_count:  r_count    <= apb.PWDATA[REP_W-1:0];
          c_addr_status: if (apb.PWDATA[1]) r_done <= 1'b0;
          default: ;
        endcase
      end

      // Sequencer assignments follow the register writes so a DONE set
      // overrides a same-cycle W1C clear.
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_led_raw <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_led_raw <= 1'b0;
            if (w_start) begin
              // LOOP comes from the same CTRL write that carries START.
              if ((r_count == '0) && !apb.PWDATA[2]) begin
                r_done <= 1'b1;
              end else begin
                r_state   <= ST_ON;
                r_led_raw <= 1'b1;
                r_timer   <= w_on_load;
                r_remain  <= r_count;
                r_done    <= 1'b0;
              end
            end
          end

          ST_ON: begin
            if (r_timer == '0) begin
              r_state   <= ST_OFF;
              r_led_raw <= 1'b0;
              r_timer   <= w_off_load;
            end else begin
              r_timer <= r_timer - c_tmr_one;
            end
          end

          ST_OFF: begin
            if (r_timer != '0) begin
              r_timer <= r_timer - c_tmr_one;
            end else if (r_loop) begin
              r_state   <= ST_ON;
              r_led_raw <= 1'b1;
              r_timer   <= w_on_load;
            end else if (r_remain <= c_rep_one) begin
              // Saturate so a looping train started with COUNT=0 ends cleanly.
              r_state   <= ST_IDLE;
              r_led_raw <= 1'b0;
              r_remain  <= '0;
              r_done    <= 1'b1;
            end else begin
              r_state   <= ST_ON;
              r_led_raw <= 1'b1;
              r_timer   <= w_on_load;
              r_remain  <= r_remain - c_rep_one;
            end
          end

          default: begin
            r_state   <= ST_IDLE;
            r_led_raw <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (w_addr)
        c_addr_ctrl:   w_rdata = {27'd0, r_irq_en, r_invert, r_loop, 2'b00};
        c_addr_on:     w_rdata = 32'(r_on_time);
        c_addr_off:    w_rdata = 32'(r_off_time);
        c_addr_count:  w_rdata = 32'(r_count);
        c_addr_status: w_rdata = {16'(r_remain), 14'd0, r_done, (r_state != ST_IDLE)};
        default:       w_rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = w_rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb.PSEL && apb.PENABLE && !w_addr_ok;

  assign LED      = r_led_raw ^ r_invert;
  assign DONE_IRQ = r_done & r_irq_en;

endmodule

`default_nettype wire
